// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - pipeline stall/flush/redirect controller
//
// Purpose: combines per-source stall requests into a per-stage freeze vector
// and turns a committed exception into a one-cycle flush followed by a
// redirect to fetch, held until fetch accepts it.
//
// Optional feature: define PIPE_CTRL_PERF_EN to build the stall-cycle and
// flush performance counters; otherwise both outputs are tied to zero.
//
// Ports:
//   clk            in   rising-edge clock
//   rst            in   synchronous active-high reset
//   stall_req      in   [NREQ]     per-source stall request (level)
//   req_stage      in   [NREQ*SW]  per-source deepest stage to freeze
//   excepttype_i   in   [32]       exception code from commit, 0 = none
//   cp0_epc_i      in   [32]       EPC used for eret
//   current_pc     in   [32]       committing PC used for refetch
//   redirect_ready in   fetch accepts new_pc this cycle
//   stall          out  [STAGES]   per-stage freeze, bit k = stage k
//   flush          out  one-cycle pipeline flush
//   new_pc         out  [32]       redirect target
//   redirect_valid out  redirect request to fetch
//   stall_cycles   out  [32]       RUN cycles with any stage stalled
//   flush_count    out  [16]       number of exceptions taken

module pipe_ctrl #(
   parameter int          STAGES  = 9,
   parameter int          NREQ    = 5,
   parameter int          SW      = 4,
   parameter logic [31:0] EXC_VEC = 32'hbfc00380
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NREQ-1:0]    stall_req,
   input  logic [NREQ*SW-1:0] req_stage,
   input  logic [31:0]        excepttype_i,
   input  logic [31:0]        cp0_epc_i,
   input  logic [31:0]        current_pc,
   input  logic               redirect_ready,
   output logic [STAGES-1:0]  stall,
   output logic               flush,
   output logic [31:0]        new_pc,
   output logic               redirect_valid,
   output logic [31:0]        stall_cycles,
   output logic [15:0]        flush_count
);

   localparam logic [1:0] RUN   = 2'd0;
   localparam logic [1:0] FLUSH = 2'd1;
   localparam logic [1:0] WAIT  = 2'd2;

   logic [1:0]        state_q, state_d;
   logic [31:0]       new_pc_q, new_pc_d;
   logic [SW-1:0]     max_stage;
   logic              any_req;
   logic [STAGES-1:0] run_mask;
   logic              exc_present;
   logic [31:0]       exc_target;

   // Out-of-range stage indices freeze the whole pipeline.
   function automatic logic [SW-1:0] clamp_stage(input logic [SW-1:0] s);
      if (int'(s) >= STAGES - 1)
         return SW'(STAGES - 1);
      return s;
   endfunction

   assign exc_present = (excepttype_i != 32'd0);

   always_comb begin
      max_stage = '0;
      any_req   = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
         if (stall_req[i]) begin
            any_req = 1'b1;
            if (clamp_stage(req_stage[i*SW +: SW]) > max_stage)
               max_stage = clamp_stage(req_stage[i*SW +: SW]);
         end
      end
   end

   // Freezing stage m implies freezing every younger stage in front of it.
   always_comb begin
      run_mask = '0;
      for (int k = 0; k < STAGES; k++)
         run_mask[k] = any_req && (k <= int'(max_stage));
   end

   always_comb begin
      case (excepttype_i)
         32'h1, 32'h4, 32'h5, 32'h8,
         32'h9, 32'ha, 32'hc, 32'hd: exc_target = EXC_VEC;
         32'he:                      exc_target = cp0_epc_i;
         32'hffffffff:               exc_target = current_pc;
         default:                    exc_target = 32'd0;
      endcase
   end

   always_comb begin
      state_d  = state_q;
      new_pc_d = new_pc_q;
      stall    = '0;
      case (state_q)
         RUN: begin
            // A pending exception wins over stalls so the flush is not delayed.
            if (exc_present) begin
               state_d  = FLUSH;
               new_pc_d = exc_target;
            end else begin
               stall = run_mask;
            end
         end
         FLUSH: state_d = redirect_ready ? RUN : WAIT;
         WAIT: begin
            stall = '1;
            if (redirect_ready)
               state_d = RUN;
         end
         default: state_d = RUN;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= RUN;
         new_pc_q <= 32'd0;
      end else begin
         state_q  <= state_d;
         new_pc_q <= new_pc_d;
      end
   end

   assign flush          = (state_q == FLUSH);
   assign redirect_valid = (state_q == FLUSH) || (state_q == WAIT);
   assign new_pc         = new_pc_q;

`ifdef PIPE_CTRL_PERF_EN
   logic [31:0] stall_cycles_q;
   logic [15:0] flush_count_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cycles_q <= 32'd0;
         flush_count_q  <= 16'd0;
      end else begin
         if ((state_q == RUN) && (|stall) && (stall_cycles_q != 32'hffffffff))
            stall_cycles_q <= stall_cycles_q + 32'd1;
         if ((state_q == RUN) && exc_present)
            flush_count_q <= flush_count_q + 16'd1;
      end
   end

   assign stall_cycles = stall_cycles_q;
   assign flush_count  = flush_count_q;
`else
   assign stall_cycles = 32'd0;
   assign flush_count  = 16'd0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb/tb_pipe_ctrl.sv - self-checking bench for pipe_ctrl
module tb_pipe_ctrl;

   localparam int STAGES = 9;
   localparam int NREQ   = 5;
   localparam int SW     = 4;
   localparam logic [31:0] EXC_VEC = 32'hbfc00380;

   logic               clk = 1'b0;
   logic               rst;
   logic [NREQ-1:0]    stall_req;
   logic [NREQ*SW-1:0] req_stage;
   logic [31:0]        excepttype_i;
   logic [31:0]        cp0_epc_i;
   logic [31:0]        current_pc;
   logic               redirect_ready;
   logic [STAGES-1:0]  stall;
   logic               flush;
   logic [31:0]        new_pc;
   logic               redirect_valid;
   logic [31:0]        stall_cycles;
   logic [15:0]        flush_count;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   pipe_ctrl #(.STAGES(STAGES), .NREQ(NREQ), .SW(SW), .EXC_VEC(EXC_VEC)) dut (
      .clk(clk), .rst(rst), .stall_req(stall_req), .req_stage(req_stage),
      .excepttype_i(excepttype_i), .cp0_epc_i(cp0_epc_i), .current_pc(current_pc),
      .redirect_ready(redirect_ready), .stall(stall), .flush(flush), .new_pc(new_pc),
      .redirect_valid(redirect_valid), .stall_cycles(stall_cycles), .flush_count(flush_count)
   );

   // Reference: deepest requested stage (clamped) -> low (m+1) bits set.
   function automatic logic [STAGES-1:0] model_stall(input logic [NREQ-1:0] req,
                                                     input logic [NREQ*SW-1:0] stg);
      int m = -1;
      int s;
      longint unsigned mask;
      for (int i = 0; i < NREQ; i++) begin
         if (req[i]) begin
            s = int'(stg[i*SW +: SW]);
            if (s > STAGES - 1) s = STAGES - 1;
            if (s > m) m = s;
         end
      end
      if (m < 0) return '0;
      mask = (64'd1 << (m + 1)) - 64'd1;
      return mask[STAGES-1:0];
   endfunction

   function automatic logic [31:0] model_pc(input logic [31:0] code, input logic [31:0] epc,
                                            input logic [31:0] cpc);
      if (code == 32'hffffffff) return cpc;
      if (code == 32'he) return epc;
      if (code inside {32'h1, 32'h4, 32'h5, 32'h8, 32'h9, 32'ha, 32'hc, 32'hd}) return EXC_VEC;
      return 32'd0;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_src(input int i, input logic on, input int stg);
      stall_req[i] = on;
      req_stage[i*SW +: SW] = SW'(stg);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      checks++; if (flush !== 1'b0) begin errors++; $display("FAIL reset_flush got %b exp 0", flush); end
      checks++; if (redirect_valid !== 1'b0) begin errors++; $display("FAIL reset_rv got %b exp 0", redirect_valid); end
      checks++; if (new_pc !== 32'd0) begin errors++; $display("FAIL reset_new_pc got %h exp 0", new_pc); end
      checks++; if (stall !== '0) begin errors++; $display("FAIL reset_stall got %h exp 0", stall); end
      checks++; if (stall_cycles !== 32'd0) begin errors++; $display("FAIL reset_stall_cycles got %0d exp 0", stall_cycles); end
      checks++; if (flush_count !== 16'd0) begin errors++; $display("FAIL reset_flush_count got %0d exp 0", flush_count); end
      rst = 1'b0;
      tick();
   endtask

   task automatic test_stall_directed();
      set_src(0, 1'b1, 3);
      set_src(2, 1'b1, 7);
      #1;
      checks++; if (stall !== 9'h0ff) begin errors++; $display("FAIL stall_two_src got %h exp 0ff", stall); end
      set_src(2, 1'b0, 7);
      #1;
      checks++; if (stall !== 9'h00f) begin errors++; $display("FAIL stall_src2_drop got %h exp 00f", stall); end
      set_src(1, 1'b1, 15);
      #1;
      checks++; if (stall !== 9'h1ff) begin errors++; $display("FAIL stall_clamp got %h exp 1ff", stall); end
      stall_req = '0;
      set_src(3, 1'b0, 12);
      set_src(4, 1'b1, 0);
      #1;
      checks++; if (stall !== 9'h001) begin errors++; $display("FAIL stall_stage0 got %h exp 001", stall); end
      stall_req = '0;
      #1;
      checks++; if (stall !== 9'h000) begin errors++; $display("FAIL stall_none got %h exp 000", stall); end
      tick();
   endtask

   task automatic test_stall_random();
      logic [STAGES-1:0] exp_s;
      for (int n = 0; n < 40; n++) begin
         stall_req = NREQ'($urandom);
         req_stage = (NREQ*SW)'({$urandom, $urandom});
         exp_s = model_stall(stall_req, req_stage);
         #1;
         checks++; if (stall !== exp_s) begin errors++; $display("FAIL stall_random[%0d] got %h exp %h", n, stall, exp_s); end
         tick();
      end
      stall_req = '0;
      tick();
   endtask

   task automatic test_exception_override();
      redirect_ready = 1'b1;
      set_src(4, 1'b1, 8);
      excepttype_i = 32'h8;
      #1;
      checks++; if (stall !== '0) begin errors++; $display("FAIL exc_override_stall got %h exp 0", stall); end
      tick();
      excepttype_i = 32'h0;
      checks++; if (flush !== 1'b1) begin errors++; $display("FAIL exc_flush got %b exp 1", flush); end
      checks++; if (redirect_valid !== 1'b1) begin errors++; $display("FAIL exc_rv got %b exp 1", redirect_valid); end
      checks++; if (new_pc !== 32'hbfc00380) begin errors++; $display("FAIL exc_new_pc got %h exp bfc00380", new_pc); end
      checks++; if (stall !== '0) begin errors++; $display("FAIL exc_flush_stall got %h exp 0", stall); end
      tick();
      checks++; if (flush !== 1'b0 || redirect_valid !== 1'b0) begin errors++; $display("FAIL exc_return got flush=%b rv=%b exp 0 0", flush, redirect_valid); end
      checks++; if (stall !== 9'h1ff) begin errors++; $display("FAIL exc_return_stall got %h exp 1ff", stall); end
      checks++; if (new_pc !== 32'hbfc00380) begin errors++; $display("FAIL exc_pc_held got %h exp bfc00380", new_pc); end
      stall_req = '0;
      tick();
   endtask

   task automatic test_wait_eret();
      redirect_ready = 1'b0;
      cp0_epc_i = 32'h80001234;
      excepttype_i = 32'he;
      tick();
      excepttype_i = 32'h0;
      cp0_epc_i = 32'h0;
      checks++; if (flush !== 1'b1 || new_pc !== 32'h80001234) begin errors++; $display("FAIL eret_flush got flush=%b pc=%h exp 1 80001234", flush, new_pc); end
      for (int c = 0; c < 3; c++) begin
         tick();
         set_src(0, 1'b1, 2);
         if (c == 2) redirect_ready = 1'b1;
         #1;
         checks++; if (flush !== 1'b0 || redirect_valid !== 1'b1) begin errors++; $display("FAIL eret_wait[%0d] got flush=%b rv=%b exp 0 1", c, flush, redirect_valid); end
         checks++; if (stall !== 9'h1ff || new_pc !== 32'h80001234) begin errors++; $display("FAIL eret_wait_hold[%0d] got stall=%h pc=%h exp 1ff 80001234", c, stall, new_pc); end
      end
      stall_req = '0;
      tick();
      redirect_ready = 1'b1;
      checks++; if (redirect_valid !== 1'b0 || flush !== 1'b0) begin errors++; $display("FAIL eret_return got rv=%b flush=%b exp 0 0", redirect_valid, flush); end
      tick();
   endtask

   task automatic test_refetch_ignore();
      redirect_ready = 1'b0;
      current_pc = 32'hbfc00100;
      excepttype_i = 32'hffffffff;
      tick();
      excepttype_i = 32'h0;
      checks++; if (new_pc !== 32'hbfc00100 || flush !== 1'b1) begin errors++; $display("FAIL refetch_pc got pc=%h flush=%b exp bfc00100 1", new_pc, flush); end
      tick();
      excepttype_i = 32'h1;
      current_pc = 32'h12345678;
      tick();
      checks++; if (new_pc !== 32'hbfc00100) begin errors++; $display("FAIL refetch_ignore_pc got %h exp bfc00100", new_pc); end
      checks++; if (flush !== 1'b0 || redirect_valid !== 1'b1) begin errors++; $display("FAIL refetch_ignore_state got flush=%b rv=%b exp 0 1", flush, redirect_valid); end
      // Reset while waiting abandons the redirect.
      rst = 1'b1;
      tick();
      rst = 1'b0;
      excepttype_i = 32'h0;
      #1;
      checks++; if (redirect_valid !== 1'b0 || flush !== 1'b0) begin errors++; $display("FAIL rst_wait_rv got rv=%b flush=%b exp 0 0", redirect_valid, flush); end
      checks++; if (stall !== '0 || new_pc !== 32'd0) begin errors++; $display("FAIL rst_wait_out got stall=%h pc=%h exp 0 0", stall, new_pc); end
      tick();
   endtask

   task automatic test_codes_random();
      logic [31:0] codes [15] = '{32'h1, 32'h4, 32'h5, 32'h8, 32'h9, 32'ha, 32'hc, 32'hd,
                                  32'he, 32'hffffffff, 32'h2, 32'h3, 32'h7, 32'hf, 32'h20};
      logic [31:0] exp_pc;
      int delay;
      for (int n = 0; n < 14; n++) begin
         excepttype_i = codes[$urandom_range(0, 14)];
         cp0_epc_i = $urandom;
         current_pc = $urandom;
         stall_req = NREQ'($urandom);
         req_stage = (NREQ*SW)'({$urandom, $urandom});
         delay = $urandom_range(0, 3);
         redirect_ready = (delay == 0);
         exp_pc = model_pc(excepttype_i, cp0_epc_i, current_pc);
         #1;
         checks++; if (stall !== '0) begin errors++; $display("FAIL rnd_exc_stall[%0d] got %h exp 0", n, stall); end
         tick();
         excepttype_i = $urandom | 32'd1;
         cp0_epc_i = $urandom;
         current_pc = $urandom;
         #1;
         checks++; if (flush !== 1'b1 || redirect_valid !== 1'b1 || new_pc !== exp_pc) begin
            errors++; $display("FAIL rnd_flush[%0d] got flush=%b rv=%b pc=%h exp 1 1 %h", n, flush, redirect_valid, new_pc, exp_pc); end
         for (int d = 1; d <= delay; d++) begin
            tick();
            redirect_ready = (d == delay);
            checks++; if (flush !== 1'b0 || redirect_valid !== 1'b1 || stall !== 9'h1ff || new_pc !== exp_pc) begin
               errors++; $display("FAIL rnd_wait[%0d] got flush=%b rv=%b stall=%h pc=%h exp 0 1 1ff %h", n, flush, redirect_valid, stall, new_pc, exp_pc); end
         end
         tick();
         excepttype_i = 32'h0;
         stall_req = '0;
         #1;
         checks++; if (flush !== 1'b0 || redirect_valid !== 1'b0 || new_pc !== exp_pc) begin
            errors++; $display("FAIL rnd_return[%0d] got flush=%b rv=%b pc=%h exp 0 0 %h", n, flush, redirect_valid, new_pc, exp_pc); end
         tick();
      end
   endtask

   task automatic test_perf();
      int exp_sc;
      int exp_fc;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      redirect_ready = 1'b1;
      set_src(1, 1'b1, 5);
      repeat (10) tick();
      stall_req = '0;
      for (int e = 0; e < 2; e++) begin
         excepttype_i = 32'h4;
         tick();
         excepttype_i = 32'h0;
         tick();
      end
      tick();
`ifdef PIPE_CTRL_PERF_EN
      exp_sc = 10;
      exp_fc = 2;
`else
      exp_sc = 0;
      exp_fc = 0;
`endif
      checks++; if (stall_cycles !== 32'(exp_sc)) begin errors++; $display("FAIL perf_stall_cycles got %0d exp %0d", stall_cycles, exp_sc); end
      checks++; if (flush_count !== 16'(exp_fc)) begin errors++; $display("FAIL perf_flush_count got %0d exp %0d", flush_count, exp_fc); end
   endtask

   initial begin
      rst = 1'b1;
      stall_req = '0;
      req_stage = '0;
      excepttype_i = 32'h0;
      cp0_epc_i = 32'h0;
      current_pc = 32'h0;
      redirect_ready = 1'b0;
      test_reset();
      test_stall_directed();
      test_stall_random();
      test_exception_override();
      test_wait_eret();
      test_refetch_ignore();
      test_codes_random();
      test_perf();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 Parameter STAGES, default 9: number of pipeline stages driven by the stall vector; stage 0 is PC/fetch.
REQ-002 Parameter NREQ, default 5: number of independent stall-request sources.
REQ-003 Parameter SW, default 4: width of each per-source stage index; SW SHALL satisfy 2^SW >= STAGES.
REQ-004 Parameter EXC_VEC, default 32'hbfc00380: general exception entry address.
REQ-005 clk  in  1  rising-edge clock.
REQ-006 rst  in  1  reset, synchronous, active-high.
REQ-007 stall_req  in  NREQ  per-source stall request, level-sensitive.
REQ-008 req_stage  in  NREQ*SW  per-source deepest stage to freeze; source i occupies bits [i*SW +: SW].
REQ-009 excepttype_i  in  32  exception code from commit; nonzero = exception present.
REQ-010 cp0_epc_i  in  32  EPC for eret.
REQ-011 current_pc  in  32  PC of the committing instruction, used for refetch.
REQ-012 redirect_ready  in  1  fetch accepts new_pc this cycle.
REQ-013 stall  out  STAGES  per-stage freeze, bit k = stage k.
REQ-014 flush  out  1  pipeline flush pulse.
REQ-015 new_pc  out  32  redirect target, valid while redirect_valid.
REQ-016 redirect_valid  out  1  redirect request to fetch.
REQ-017 stall_cycles  out  32  performance counter (see Configuration).
REQ-018 flush_count  out  16  performance counter (see Configuration).

Function
REQ-019 FSM states SHALL be RUN, FLUSH, WAIT.
REQ-020 In RUN, stall SHALL be combinational, same cycle: stall[k]=1 for every k <= m, where m is the maximum req_stage over all active stall_req; all zero if no request is active.
REQ-021 A req_stage value >= STAGES SHALL be treated as STAGES-1.
REQ-022 In RUN, excepttype_i != 0 at a rising edge SHALL move the FSM to FLUSH and register new_pc from the code; this overrides any stall request.
REQ-023 Code mapping: 1,4,5,8,9,a,c,d -> EXC_VEC; e -> cp0_epc_i; ffffffff -> current_pc; any other nonzero code -> 0. The operand SHALL be sampled at the accepting edge.
REQ-024 In RUN, while excepttype_i is nonzero, stall SHALL be all zero.
REQ-025 FLUSH: flush=1 and redirect_valid=1 for exactly one cycle; stall all zero.
REQ-026 FLUSH with redirect_ready=1 -> RUN; with redirect_ready=0 -> WAIT.
REQ-027 WAIT: flush=0, redirect_valid=1, new_pc held, stall all ones; redirect_ready=1 -> RUN.
REQ-028 excepttype_i and stall_req SHALL be ignored in FLUSH and WAIT.
REQ-029 In RUN, flush=0 and redirect_valid=0; new_pc keeps its last value.
REQ-030 Exception latency: exception code at edge N -> flush high in cycle N+1; earliest redirect completion in cycle N+1.

Reset
REQ-031 When rst is sampled high: state=RUN, new_pc=0, flush=0, redirect_valid=0, stall=0, and both counters =0.
REQ-032 Reset in FLUSH or WAIT SHALL abandon the redirect; no flush or redirect_valid in the cycle after reset.

Configuration
REQ-033 Macro PIPE_CTRL_PERF_EN defined: stall_cycles SHALL increment, saturating at 32'hffffffff, on each RUN cycle with stall != 0; flush_count SHALL increment, wrapping, on each RUN->FLUSH transition.
REQ-034 Macro PIPE_CTRL_PERF_EN not defined: stall_cycles and flush_count SHALL be constant 0 and no counter registers SHALL exist.

Verification
REQ-035 Stimulus: STAGES=9, source0 stage 3 and source2 stage 7 active. Required: stall=9'h0ff; after source2 drops, stall=9'h00f.
REQ-036 Stimulus: excepttype_i=32'h8 while a stage-8 request is active. Required: stall=0 in the same cycle; next cycle flush=1, new_pc=bfc00380, redirect_valid=1.
REQ-037 Stimulus: excepttype_i=32'he with cp0_epc_i=32'h80001234, redirect_ready held 0 for 3 cycles. Required: flush lasts 1 cycle, then WAIT with stall=1ff and new_pc held; return to RUN on the redirect_ready edge.
REQ-038 Stimulus: excepttype_i=32'hffffffff with current_pc=32'hbfc00100, then a second exception during WAIT. Required: new_pc=bfc00100; the second exception is ignored.
REQ-039 Stimulus: rst asserted during WAIT. Required: next cycle redirect_valid=0, flush=0, stall=0, new_pc=0.
REQ-040 Stimulus: PERF_EN on, 10 stalled RUN cycles and 2 exceptions. Required: stall_cycles=10, flush_count=2; with PERF_EN off, both read 0.
